// File: rtl/fp_addsub.sv
// fp_addsub: multi-cycle IEEE-754 add/subtract, round-to-nearest-even, subnormals, {invalid,overflow,inexact} flags
module fp_addsub #(
   parameter int EXP_W = 11,
   parameter int FRAC_W = 52,
   localparam int W = 1 + EXP_W + FRAC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] input_a,
   input  logic         input_a_stb,
   output logic         input_a_ack,
   input  logic [W-1:0] input_b,
   input  logic         op,
   input  logic         input_b_stb,
   output logic         input_b_ack,
   output logic [W-1:0] output_z,
   output logic [2:0]   output_z_flags,
   output logic         output_z_stb,
   input  logic         output_z_ack
);
   localparam int E = EXP_W;
   localparam int F = FRAC_W;
   localparam int M = F + 4;
   localparam logic [E:0] E_MAX = {1'b0, {E{1'b1}}};
   typedef enum logic [3:0] {GET_A, GET_B, UNPACK, SPECIAL, ADD, NORM, ROUND, PACK, PUT_Z} state_t;
   state_t state, state_n;
   logic [W-1:0] a, b;
   logic b_op, a_s, b_s, z_s, eff_sub, inexact;
   logic [E:0] a_e, b_e, z_e, norm_e, rnd_e;
   logic [F:0] a_m, b_m, sig, rnd_sig;
   logic [F+1:0] rnd;
   logic [M-1:0] x_m, y_m, ext, shifted, aligned;
   logic [M:0] sum, sum_n, norm_m;
   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, invalid, special, a_big, lost, up, ovf;
   logic [W-1:0] spec_z;
   logic a_ack_n, b_ack_n, z_stb_n;
   int shift_d, lz, sh;
   // Exponents are kept biased, with subnormals given the effective exponent 1
   always_comb begin
      a_nan = &a[W-2:F] && |a[F-1:0];
      b_nan = &b[W-2:F] && |b[F-1:0];
      a_inf = &a[W-2:F] && a[F-1:0] == '0;
      b_inf = &b[W-2:F] && b[F-1:0] == '0;
      a_zero = a[W-2:0] == '0;
      b_zero = b[W-2:0] == '0;
      invalid = a_nan | b_nan | (a_inf & b_inf & (a_s ^ b_s));
      special = invalid | a_inf | b_inf | a_zero | b_zero;
      spec_z = invalid ? {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}} :
               a_inf ? {a_s, a[W-2:0]} :
               b_inf ? {b_s, b[W-2:0]} :
               (a_zero & b_zero) ? {a_s & b_s, {(W-1){1'b0}}} :
               a_zero ? {b_s, b[W-2:0]} : {a_s, a[W-2:0]};
      a_big = a[W-2:0] >= b[W-2:0];
      shift_d = a_big ? int'(a_e) - int'(b_e) : int'(b_e) - int'(a_e);
      shift_d = shift_d > M - 1 ? M - 1 : shift_d;
      ext = {a_big ? b_m : a_m, 3'b000};
      shifted = ext >> shift_d;
      lost = |(ext & ~({M{1'b1}} << shift_d));
      aligned = {shifted[M-1:1], shifted[0] | lost};
   end
   always_comb begin
      sum_n = eff_sub ? {1'b0, x_m} - {1'b0, y_m} : {1'b0, x_m} + {1'b0, y_m};
      lz = M;
      for (int i = 0; i < M; i++) if (sum[i]) lz = M - 1 - i;
      sh = lz < int'(z_e) - 1 ? lz : int'(z_e) - 1;
      norm_m = sum[M] ? {1'b0, sum[M:2], sum[1] | sum[0]} : sum << sh;
      norm_e = sum[M] ? z_e + 1'b1 : z_e - (E+1)'(sh);
      up = sum[2] & (sum[1] | sum[0] | sum[3]);
      rnd = {1'b0, sum[M-1:3]} + (F+2)'(up);
      rnd_e = rnd[F+1] ? z_e + 1'b1 : z_e;
      rnd_sig = rnd[F+1] ? rnd[F+1:1] : rnd[F:0];
      ovf = z_e >= E_MAX;
   end
   always_comb begin
      state_n = state;
      case (state)
         GET_A:   state_n = (input_a_stb && input_a_ack) ? GET_B : GET_A;
         GET_B:   state_n = (input_b_stb && input_b_ack) ? UNPACK : GET_B;
         UNPACK:  state_n = SPECIAL;
         SPECIAL: state_n = special ? PUT_Z : ADD;
         ADD:     state_n = NORM;
         NORM:    state_n = ROUND;
         ROUND:   state_n = PACK;
         PACK:    state_n = PUT_Z;
         PUT_Z:   state_n = output_z_ack ? GET_A : PUT_Z;
         default: state_n = GET_A;
      endcase
   end
   always_comb begin
      a_ack_n = state == GET_A && !(input_a_stb && input_a_ack);
      b_ack_n = state == GET_B && !(input_b_stb && input_b_ack);
      z_stb_n = (state == SPECIAL && special) || state == PACK || (state == PUT_Z && !output_z_ack);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= GET_A;
         input_a_ack <= 1'b0;
         input_b_ack <= 1'b0;
         output_z_stb <= 1'b0;
      end else begin
         state <= state_n;
         input_a_ack <= a_ack_n;
         input_b_ack <= b_ack_n;
         output_z_stb <= z_stb_n;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         output_z <= '0;
         output_z_flags <= '0;
      end else begin
         case (state)
            GET_A: if (input_a_stb && input_a_ack) a <= input_a;
            GET_B: if (input_b_stb && input_b_ack) begin
               b <= input_b;
               b_op <= op;
            end
            UNPACK: begin
               a_s <= a[W-1];
               b_s <= b[W-1] ^ b_op;
               a_e <= (a[W-2:F] == '0) ? (E+1)'(1) : {1'b0, a[W-2:F]};
               b_e <= (b[W-2:F] == '0) ? (E+1)'(1) : {1'b0, b[W-2:F]};
               a_m <= {|a[W-2:F], a[F-1:0]};
               b_m <= {|b[W-2:F], b[F-1:0]};
            end
            SPECIAL: if (special) begin
               output_z <= spec_z;
               output_z_flags <= {invalid, 2'b00};
            end else begin
               z_s <= a_big ? a_s : b_s;
               z_e <= a_big ? a_e : b_e;
               x_m <= {a_big ? a_m : b_m, 3'b000};
               y_m <= aligned;
               eff_sub <= a_s ^ b_s;
            end
            ADD: begin
               sum <= sum_n;
               z_s <= (sum_n == '0) ? 1'b0 : z_s;
            end
            NORM: begin
               sum <= norm_m;
               z_e <= norm_e;
            end
            ROUND: begin
               sig <= rnd_sig;
               z_e <= rnd_e;
               inexact <= |sum[2:0];
            end
            PACK: begin
               output_z <= ovf ? {z_s, {E{1'b1}}, {F{1'b0}}} : {z_s, sig[F] ? z_e[E-1:0] : {E{1'b0}}, sig[F-1:0]};
               output_z_flags <= ovf ? 3'b011 : {2'b00, inexact};
            end
            default: ;
         endcase
      end
   end
endmodule
